sum_frame_ctrl: RTL and testbench



---
 rtl/udp_sum_pkg.sv | 18 +
 rtl/sum_result_fifo.sv | 50 +++++
 rtl/sum_frame_ctrl.sv | 93 +++++++++
 tb/tb_sum_frame_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/udp_sum_pkg.sv
// Shared types and constants for the UDP payload sum controller.
package udp_sum_pkg;
  localparam int SUM_LAT    = 3;
  localparam int WORDS      = 8;
  localparam int WORD_W     = 32;
  localparam int RES_BEAT_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0]     sum;
    logic [RES_BEAT_W-1:0] beats;
  } sum_result_t;

  // One stage of the latency-matching delay line
  typedef struct packed {
    logic                  last;
    logic [RES_BEAT_W-1:0] beats;
  } dl_entry_t;
endpackage

// File: rtl/sum_result_fifo.sv
// First-word fall-through FIFO holding completed frame sums.
module sum_result_fifo
  import udp_sum_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sum_result_t   push_data,
  input  logic          pop,
  output sum_result_t   rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);
  sum_result_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream flow control reserves a slot for every in-flight frame end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/sum_frame_ctrl.sv
// Frame controller around the tree-adder sum stage: feeds beats, tracks the
// stage latency and captures per-frame sums into a result FIFO.
module sum_frame_ctrl
  import udp_sum_pkg::*;
#(
  parameter int RES_DEPTH = 4,
  parameter int BEAT_W    = RES_BEAT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORDS*WORD_W-1:0]   s_data,
  input  logic [WORDS-1:0]          s_keep,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [WORDS*WORD_W-1:0]   sum_payload,
  output logic                      sum_ce,
  output logic                      sum_clear,
  input  logic [WORD_W-1:0]         sum_in,
  output logic [WORD_W-1:0]         m_sum,
  output logic [BEAT_W-1:0]         m_beats,
  output logic                      m_valid,
  input  logic                      m_ready
);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int IW = $clog2(SUM_LAT + 1);

  logic accept;
  logic [BEAT_W-1:0] beat_cnt, beat_inc;
  dl_entry_t [SUM_LAT-1:0] dl;
  logic [IW-1:0] inflight;
  logic [CW:0] occ;
  logic [CW-1:0] fifo_count;
  logic fifo_empty;
  sum_result_t push_data, rd_data;

  assign accept = s_valid && s_ready;

  always_comb begin
    sum_payload = '0;
    for (int w = 0; w < WORDS; w++)
      if (accept && s_keep[w]) sum_payload[w*WORD_W +: WORD_W] = s_data[w*WORD_W +: WORD_W];
  end

  // Holding CE low while in reset clears the whole sum stage
  always_ff @(posedge clk) begin
    if (rst) sum_ce <= 1'b0;
    else     sum_ce <= 1'b1;
  end

  assign beat_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst)         beat_cnt <= '0;
    else if (accept) beat_cnt <= s_last ? '0 : beat_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl <= '0;
    end else begin
      dl[0] <= '{last: accept && s_last, beats: RES_BEAT_W'(beat_inc)};
      for (int i = 1; i < SUM_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SUM_LAT; i++) inflight = inflight + IW'(dl[i].last);
  end

  assign occ     = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign s_ready = sum_ce && (occ < (CW+1)'(RES_DEPTH));

  // Capture and clear on the same edge so the next frame starts from zero
  assign sum_clear = dl[SUM_LAT-1].last;
  assign push_data = '{sum: sum_in, beats: dl[SUM_LAT-1].beats};

  sum_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sum_clear),
    .push_data (push_data),
    .pop       (m_ready),
    .rd_data   (rd_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_sum   = m_valid ? rd_data.sum : '0;
  assign m_beats = m_valid ? BEAT_W'(rd_data.beats) : '0;
endmodule

// File: tb/tb_sum_frame_ctrl.sv
// Directed bench for sum_frame_ctrl with a behavioural 3-cycle sum stage.
module tb_sum_frame_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_data;
  logic [7:0]   s_keep;
  logic         s_valid, s_last, s_ready;
  logic [255:0] sum_payload;
  logic         sum_ce, sum_clear;
  logic [31:0]  sum_in;
  logic [31:0]  m_sum;
  logic [15:0]  m_beats;
  logic         m_valid, m_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sum_frame_ctrl #(.RES_DEPTH(4), .BEAT_W(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .sum_payload(sum_payload), .sum_ce(sum_ce),
    .sum_clear(sum_clear), .sum_in(sum_in), .m_sum(m_sum), .m_beats(m_beats),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  // External sum stage: tree sum, pipeline register, accumulator with clear_mem
  logic [31:0] t0, t1, acc;
  function automatic logic [31:0] tree(input logic [255:0] p);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 8; i++) s = s + p[32*i +: 32];
    return s;
  endfunction
  always @(posedge clk) begin
    if (!sum_ce) begin
      t0 <= 32'd0; t1 <= 32'd0; acc <= 32'd0;
    end else begin
      t0  <= tree(sum_payload);
      t1  <= t0;
      acc <= (sum_clear ? 32'd0 : acc) + t1;
    end
  end
  assign sum_in = acc;

  function automatic logic [255:0] rep(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge
  task automatic send(input logic [255:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] es, input logic [15:0] eb);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_sum"}, m_sum, es);
    chk({tag, "_beats"}, m_beats, eb);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_sum_ce", sum_ce, 0);
    chk("rst_sum_clear", sum_clear, 0);
    chk("rst_sum_payload", sum_payload, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sum", m_sum, 0);
    chk("rst_m_beats", m_beats, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ce_after_rst", sum_ce, 1);
    chk("ready_after_rst", s_ready, 1);

    // Single-beat frame, with latency check
    send(rep(32'd1), 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet", m_valid, 0);
    chk("lat_clear", sum_clear, 1);
    @(negedge clk);
    chk("lat_valid", m_valid, 1);
    chk("one_sum", m_sum, 32'd8);
    chk("one_beats", m_beats, 16'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("drained", m_valid, 0);
    @(posedge clk); #1;

    // 3-beat frame then back-to-back 1-beat frame
    send(rep(32'h10), 8'hFF, 1'b0);
    send(rep(32'h20), 8'hFF, 1'b0);
    send(rep(32'h30), 8'hFF, 1'b1);
    send(rep(32'h2),  8'hFF, 1'b1);
    expect_result("f3", 32'h300, 16'd3);
    expect_result("f1b", 32'h10, 16'd1);

    // Keep masking on last beat
    send(rep(32'd5), 8'hFF, 1'b0);
    s_data = rep(32'd5); s_keep = 8'h0F; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    chk("mask_payload", sum_payload, {128'd0, {4{32'd5}}});
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    expect_result("mask", 32'd60, 16'd2);

    // Modulo-2^32 wrap
    send({224'd0, 32'hFFFF_FFFF}, 8'hFF, 1'b0);
    send({224'd0, 32'hFFFF_FFFF}, 8'hFF, 1'b1);
    send({192'd0, 32'h8000_0000, 32'h8000_0000}, 8'hFF, 1'b1);
    expect_result("wrap1", 32'hFFFF_FFFE, 16'd2);
    expect_result("wrap2", 32'h0, 16'd1);

    // Backpressure: only four frames fit in fifo + delay line
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(rep(32'(i + 1)), 8'hFF, 1'b1);
    @(negedge clk);
    chk("bp_ready_drop", s_ready, 0);
    s_data = rep(32'd5); s_keep = 8'hFF; s_last = 1'b1; s_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_still_blocked", s_ready, 0);
    chk("bp_head_valid", m_valid, 1);
    chk("bp_head_sum", m_sum, 32'd8);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) expect_result("bp_a", 32'(8 * (i + 1)), 16'd1);
    @(negedge clk);
    chk("bp_empty", m_valid, 0);
    @(posedge clk); #1;
    for (int i = 4; i < 8; i++) send(rep(32'(i + 1)), 8'hFF, 1'b1);
    for (int i = 4; i < 8; i++) expect_result("bp_b", 32'(8 * (i + 1)), 16'd1);

    // Reset mid-frame discards the partial frame
    send(rep(32'd7), 8'hFF, 1'b0);
    send(rep(32'd7), 8'hFF, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_result", m_valid, 0);
    @(posedge clk); #1;
    send(rep(32'd3), 8'hFF, 1'b1);
    expect_result("after_rst", 32'd24, 16'd1);
    @(negedge clk);
    chk("final_empty", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
